pipe_ir_chain: RTL and testbench
================================

Name: pipe_ir_chain

Overview:
- Produces the per-stage instruction words that the pipeline control decoder consumes: the DEC, EXE, MEM and WB IR/PC registers of the OTTER pipeline.
- Consumes that decoder's CLEAR and INT_TAKEN back, to squash the wrong path.
- Detects load-use hazards, stalls fetch/decode and injects bubbles.
- Keeps saturating stall/flush event counters for bring-up.

Parameters:
- XLEN, 32, instruction/PC width.
- NOP_INSTR, 32'h00000013, bubble encoding (ADDI x0,x0,0).
- CNT_W, 16, width of stall/flush event counters.

Ports:
- CLK  in  1  clock, all state on rising edge.
- RST  in  1  synchronous, active-high reset.
- IF_IR  in  XLEN  fetched instruction.
- IF_PC  in  XLEN  PC of IF_IR.
- IF_VALID  in  1  IF_IR/IF_PC are valid this cycle.
- CLEAR  in  1  taken branch/jump resolved in EXE; squash younger stages.
- INT_TAKEN  in  1  interrupt taken in EXE; same squash as CLEAR.
- STALL  out  1  combinational; high means fetch PC must hold and IF_IR is not consumed.
- DEC_IR, EXE_IR, MEM_IR, WB_IR  out  XLEN each  per-stage instruction registers.
- DEC_PC, EXE_PC, MEM_PC, WB_PC  out  XLEN each  per-stage PC registers.
- DEC_V, EXE_V, MEM_V, WB_V  out  1 each  stage holds a real (non-bubble) instruction.
- STALL_CNT  out  CNT_W  cycles with STALL=1, saturating.
- FLUSH_CNT  out  CNT_W  cycles with CLEAR|INT_TAKEN, saturating.

Behaviour:
- Reset (RST=1 at an edge): all IRs = NOP_INSTR; all PCs = 0; all V = 0; both counters = 0. STALL evaluates from the reset state, so it is 0 after reset. Reset overrides every other input and may occur mid-stall or mid-flush with no residue.
- Normal advance (no stall, no flush), each edge:
  - WB <= MEM; MEM <= EXE; EXE <= DEC (IR, PC, V move together).
  - DEC <= IF_VALID ? {IF_IR, IF_PC, 1} : {NOP_INSTR, IF_PC, 0}.
- Latency: an instruction accepted at edge n is in DEC after n, EXE after n+1, MEM after n+2, WB after n+3.
- Load-use hazard (combinational, computed in sub-module), asserted when all of:
  - EXE_V = 1;
  - EXE_IR[6:0] = LOAD;
  - rd = EXE_IR[11:7] != 0;
  - DEC_V = 1, and either (DEC uses rs1 and DEC_IR[19:15] = rd) or (DEC uses rs2 and DEC_IR[24:20] = rd).
- Register use by opcode:
  - rs1 used by JALR, BRANCH, LOAD, STORE, OP_IMM, OP, and SYSTEM with func3[2]=0.
  - rs2 used by BRANCH, STORE, OP.
  - LUI, AUIPC, JAL and unknown opcodes use neither.
- STALL = hazard AND NOT (CLEAR | INT_TAKEN).
- On a STALL edge:
  - DEC holds;
  - EXE <= {NOP_INSTR, DEC_PC, 0};
  - MEM and WB advance normally;
  - IF_IR is ignored.
- The stall lasts exactly 1 cycle per hazard, because the load moves to MEM.
- On a flush edge (CLEAR | INT_TAKEN):
  - DEC <= {NOP_INSTR, IF_PC, 0};
  - EXE <= {NOP_INSTR, DEC_PC, 0};
  - MEM <= EXE (the branch/jump itself retires);
  - WB <= MEM.
  - Flush has priority over stall. CLEAR and INT_TAKEN together behave as a single flush.
- Counters:
  - STALL_CNT increments on each STALL edge; FLUSH_CNT increments on each flush edge.
  - Both hold at 2^CNT_W-1 and never wrap.
- x0 destination never causes a hazard. Bubbles (V=0) never cause a hazard regardless of IR contents.

Decomposition:
- Shared package otter_pkg holds:
  - opcode_t enum (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, SYSTEM);
  - func3_t branch enum;
  - NOP constant 32'h00000013.
- The control decoder imports the same package.
- One combinational sub-module, load_use_detect: inputs EXE_IR, EXE_V, DEC_IR, DEC_V; output hazard.

Test Plan:
- Reset then 4 fetches of valid ADDI at PCs 0,4,8,C -> the PC=0 instruction reaches WB_IR after 4 edges; WB_V=1; STALL stays 0; counters 0.
- LW x5,0(x1) followed by ADD x6,x5,x2 -> STALL=1 for exactly one cycle; EXE gets a NOP with EXE_V=0; ADD enters EXE one cycle late; STALL_CNT=1.
- LW x0,0(x1) followed by ADD x6,x0,x0, and LW x5 followed by LUI x5 -> STALL never asserts.
- BEQ in EXE with CLEAR=1 while the hazard condition is also true -> no stall; DEC and EXE become NOP with V=0; BEQ moves to MEM; FLUSH_CNT=1; STALL_CNT unchanged.
- INT_TAKEN=1 together with CLEAR=1 for one cycle -> identical squash, FLUSH_CNT increments by 1. Then RST asserted during a stall -> all stages NOP/0, STALL=0 on the next cycle.
- Force STALL_CNT to 16'hFFFF via repeated hazards (or a shortened CNT_W=2 build: 4 hazards) -> the counter saturates at the maximum value and does not wrap.

Source files
------------

// File: rtl/otter_pkg.sv
// Shared OTTER pipeline definitions: opcodes, branch func3 codes, bubble
// encoding and the register-use decode shared by hazard logic and decoder.
package otter_pkg;

   typedef enum logic [6:0] {
      LUI    = 7'b0110111,
      AUIPC  = 7'b0010111,
      JAL    = 7'b1101111,
      JALR   = 7'b1100111,
      BRANCH = 7'b1100011,
      LOAD   = 7'b0000011,
      STORE  = 7'b0100011,
      OP_IMM = 7'b0010011,
      OP     = 7'b0110011,
      SYSTEM = 7'b1110011
   } opcode_t;

   typedef enum logic [2:0] {
      BEQ  = 3'b000,
      BNE  = 3'b001,
      BLT  = 3'b100,
      BGE  = 3'b101,
      BLTU = 3'b110,
      BGEU = 3'b111
   } func3_t;

   // ADDI x0,x0,0
   localparam logic [31:0] NOP = 32'h00000013;

   // SYSTEM reads rs1 only for the register forms of CSR access (func3[2]=0)
   function automatic logic uses_rs1(input logic [6:0] opc, input logic [2:0] f3);
      logic r;
      r = 1'b0;
      case (opc)
         JALR, BRANCH, LOAD, STORE, OP_IMM, OP: r = 1'b1;
         SYSTEM:                                r = ~f3[2];
         default:                               r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic uses_rs2(input logic [6:0] opc);
      logic r;
      r = 1'b0;
      case (opc)
         BRANCH, STORE, OP: r = 1'b1;
         default:           r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard: a valid load in EXE writes a register that
// the valid instruction in DEC reads.
module load_use_detect
   import otter_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] EXE_IR,
   input  logic            EXE_V,
   input  logic [XLEN-1:0] DEC_IR,
   input  logic            DEC_V,
   output logic            hazard
);

   logic [4:0] w_rd;
   logic       w_exe_load;
   logic       w_rs1_hit;
   logic       w_rs2_hit;
   logic       w_unused;

   assign w_unused = ^{EXE_IR[XLEN-1:12], DEC_IR[11:7], DEC_IR[XLEN-1:25]};

   // x0 writes are architecturally discarded, so they never create a hazard
   always_comb begin
      w_rd       = EXE_IR[11:7];
      w_exe_load = EXE_V && (EXE_IR[6:0] == LOAD) && (w_rd != 5'd0);
      w_rs1_hit  = uses_rs1(DEC_IR[6:0], DEC_IR[14:12]) && (DEC_IR[19:15] == w_rd);
      w_rs2_hit  = uses_rs2(DEC_IR[6:0]) && (DEC_IR[24:20] == w_rd);
      hazard     = w_exe_load && DEC_V && (w_rs1_hit || w_rs2_hit);
   end

endmodule

// File: rtl/pipe_ir_chain.sv
// DEC/EXE/MEM/WB instruction and PC registers with load-use stall, branch or
// interrupt squash, and saturating stall/flush event counters.
module pipe_ir_chain
   import otter_pkg::*;
#(
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(NOP),
   parameter int unsigned     CNT_W     = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [XLEN-1:0]  IF_IR,
   input  logic [XLEN-1:0]  IF_PC,
   input  logic             IF_VALID,
   input  logic             CLEAR,
   input  logic             INT_TAKEN,
   output logic             STALL,
   output logic [XLEN-1:0]  DEC_IR,
   output logic [XLEN-1:0]  EXE_IR,
   output logic [XLEN-1:0]  MEM_IR,
   output logic [XLEN-1:0]  WB_IR,
   output logic [XLEN-1:0]  DEC_PC,
   output logic [XLEN-1:0]  EXE_PC,
   output logic [XLEN-1:0]  MEM_PC,
   output logic [XLEN-1:0]  WB_PC,
   output logic             DEC_V,
   output logic             EXE_V,
   output logic             MEM_V,
   output logic             WB_V,
   output logic [CNT_W-1:0] STALL_CNT,
   output logic [CNT_W-1:0] FLUSH_CNT
);

   logic [XLEN-1:0]  r_dec_ir, r_exe_ir, r_mem_ir, r_wb_ir;
   logic [XLEN-1:0]  r_dec_pc, r_exe_pc, r_mem_pc, r_wb_pc;
   logic             r_dec_v, r_exe_v, r_mem_v, r_wb_v;
   logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
   logic             w_hazard;
   logic             w_flush;
   logic             w_stall;

   load_use_detect #(
      .XLEN (XLEN)
   ) u_load_use_detect (
      .EXE_IR (r_exe_ir),
      .EXE_V  (r_exe_v),
      .DEC_IR (r_dec_ir),
      .DEC_V  (r_dec_v),
      .hazard (w_hazard)
   );

   // Squash outranks stall: the stalled instruction is on the wrong path anyway
   always_comb begin
      w_flush = CLEAR | INT_TAKEN;
      w_stall = w_hazard & ~w_flush;
   end

   // Stage registers: MEM/WB always advance, DEC/EXE depend on flush/stall
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_dec_ir <= NOP_INSTR; r_exe_ir <= NOP_INSTR;
         r_mem_ir <= NOP_INSTR; r_wb_ir  <= NOP_INSTR;
         r_dec_pc <= '0; r_exe_pc <= '0; r_mem_pc <= '0; r_wb_pc <= '0;
         r_dec_v  <= 1'b0; r_exe_v <= 1'b0; r_mem_v <= 1'b0; r_wb_v <= 1'b0;
      end else begin
         r_wb_ir  <= r_mem_ir; r_wb_pc  <= r_mem_pc; r_wb_v  <= r_mem_v;
         r_mem_ir <= r_exe_ir; r_mem_pc <= r_exe_pc; r_mem_v <= r_exe_v;
         if (w_flush) begin
            r_exe_ir <= NOP_INSTR; r_exe_pc <= r_dec_pc; r_exe_v <= 1'b0;
            r_dec_ir <= NOP_INSTR; r_dec_pc <= IF_PC;    r_dec_v <= 1'b0;
         end else if (w_stall) begin
            r_exe_ir <= NOP_INSTR; r_exe_pc <= r_dec_pc; r_exe_v <= 1'b0;
         end else begin
            r_exe_ir <= r_dec_ir; r_exe_pc <= r_dec_pc; r_exe_v <= r_dec_v;
            r_dec_ir <= IF_VALID ? IF_IR : NOP_INSTR;
            r_dec_pc <= IF_PC;
            r_dec_v  <= IF_VALID;
         end
      end
   end

   // Saturating event counters
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (w_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   // Drive outputs from the stage registers
   always_comb begin
      STALL     = w_stall;
      DEC_IR    = r_dec_ir; EXE_IR = r_exe_ir; MEM_IR = r_mem_ir; WB_IR = r_wb_ir;
      DEC_PC    = r_dec_pc; EXE_PC = r_exe_pc; MEM_PC = r_mem_pc; WB_PC = r_wb_pc;
      DEC_V     = r_dec_v;  EXE_V  = r_exe_v;  MEM_V  = r_mem_v;  WB_V  = r_wb_v;
      STALL_CNT = r_stall_cnt;
      FLUSH_CNT = r_flush_cnt;
   end

endmodule

// File: tb/tb_pipe_ir_chain.sv
// Directed bench for pipe_ir_chain, built with 2-bit counters so saturation
// is reachable in a handful of hazards.
module tb_pipe_ir_chain;

   localparam int unsigned CW = 2;
   localparam logic [31:0] NOPI  = 32'h00000013;
   localparam logic [31:0] ADDI1 = 32'h00100093; // addi x1,x0,1
   localparam logic [31:0] ADDI2 = 32'h00100113; // addi x2,x0,1
   localparam logic [31:0] ADDI3 = 32'h00100193; // addi x3,x0,1
   localparam logic [31:0] ADDI4 = 32'h00100213; // addi x4,x0,1
   localparam logic [31:0] LW5   = 32'h0000A283; // lw x5,0(x1)
   localparam logic [31:0] LW0   = 32'h0000A003; // lw x0,0(x1)
   localparam logic [31:0] ADD65 = 32'h00228333; // add x6,x5,x2
   localparam logic [31:0] ADD60 = 32'h00000333; // add x6,x0,x0
   localparam logic [31:0] LUI5  = 32'h000002B7; // lui x5,0

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [31:0]   if_ir = NOPI;
   logic [31:0]   if_pc = '0;
   logic          if_valid = 1'b0;
   logic          clear = 1'b0;
   logic          int_taken = 1'b0;
   logic          stall;
   logic [31:0]   dec_ir, exe_ir, mem_ir, wb_ir;
   logic [31:0]   dec_pc, exe_pc, mem_pc, wb_pc;
   logic          dec_v, exe_v, mem_v, wb_v;
   logic [CW-1:0] stall_cnt, flush_cnt;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   pipe_ir_chain #(
      .XLEN      (32),
      .NOP_INSTR (NOPI),
      .CNT_W     (CW)
   ) dut (
      .CLK       (clk),
      .RST       (rst),
      .IF_IR     (if_ir),
      .IF_PC     (if_pc),
      .IF_VALID  (if_valid),
      .CLEAR     (clear),
      .INT_TAKEN (int_taken),
      .STALL     (stall),
      .DEC_IR    (dec_ir),
      .EXE_IR    (exe_ir),
      .MEM_IR    (mem_ir),
      .WB_IR     (wb_ir),
      .DEC_PC    (dec_pc),
      .EXE_PC    (exe_pc),
      .MEM_PC    (mem_pc),
      .WB_PC     (wb_pc),
      .DEC_V     (dec_v),
      .EXE_V     (exe_v),
      .MEM_V     (mem_v),
      .WB_V      (wb_v),
      .STALL_CNT (stall_cnt),
      .FLUSH_CNT (flush_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [31:0] ir, input logic [31:0] pc);
      if_ir    = ir;
      if_pc    = pc;
      if_valid = 1'b1;
   endtask

   initial begin
      // Reset
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_dec_ir", dec_ir, NOPI);
      check("rst_wb_ir", wb_ir, NOPI);
      check("rst_exe_pc", exe_pc, 32'h0);
      check("rst_valids", {28'h0, dec_v, exe_v, mem_v, wb_v}, 32'h0);
      check("rst_cnts", {28'h0, stall_cnt, flush_cnt}, 32'h0);
      check("rst_stall", {31'h0, stall}, 32'h0);

      // Four independent instructions flow to WB
      fetch(ADDI1, 32'h0);  tick();
      fetch(ADDI2, 32'h4);  tick();
      check("adv_stall", {31'h0, stall}, 32'h0);
      fetch(ADDI3, 32'h8);  tick();
      fetch(ADDI4, 32'hC);  tick();
      check("adv_wb_ir", wb_ir, ADDI1);
      check("adv_wb_pc", wb_pc, 32'h0);
      check("adv_wb_v", {31'h0, wb_v}, 32'h1);
      check("adv_mem_ir", mem_ir, ADDI2);
      check("adv_dec_pc", dec_pc, 32'hC);
      check("adv_cnts", {28'h0, stall_cnt, flush_cnt}, 32'h0);

      // Load-use: lw x5 then add x6,x5,x2
      fetch(LW5, 32'h10);   tick();
      fetch(ADD65, 32'h14); tick();
      fetch(ADDI1, 32'h18);
      #1;
      check("lu_stall_hi", {31'h0, stall}, 32'h1);
      tick();
      check("lu_dec_hold_ir", dec_ir, ADD65);
      check("lu_dec_hold_pc", dec_pc, 32'h14);
      check("lu_exe_bubble", exe_ir, NOPI);
      check("lu_exe_v", {31'h0, exe_v}, 32'h0);
      check("lu_exe_pc", exe_pc, 32'h14);
      check("lu_mem_ir", mem_ir, LW5);
      check("lu_stall_cnt", {30'h0, stall_cnt}, 32'h1);
      check("lu_stall_lo", {31'h0, stall}, 32'h0);
      tick();
      check("lu_exe_add", exe_ir, ADD65);
      check("lu_exe_add_pc", exe_pc, 32'h14);
      check("lu_dec_next", dec_pc, 32'h18);
      check("lu_stall_cnt2", {30'h0, stall_cnt}, 32'h1);

      // No hazard: x0 destination, and LUI that reads no registers
      fetch(LW0, 32'h20);   tick();
      fetch(ADD60, 32'h24); tick();
      check("nh_x0_stall", {31'h0, stall}, 32'h0);
      fetch(LW5, 32'h28);   tick();
      fetch(LUI5, 32'h2C);  tick();
      check("nh_lui_exe", exe_ir, LW5);
      check("nh_lui_stall", {31'h0, stall}, 32'h0);
      tick();
      check("nh_stall_cnt", {30'h0, stall_cnt}, 32'h1);

      // Flush while the hazard condition holds
      fetch(LW5, 32'h30);   tick();
      fetch(ADD65, 32'h34); tick();
      fetch(ADDI1, 32'h38);
      #1;
      check("fl_hazard", {31'h0, stall}, 32'h1);
      clear = 1'b1;
      #1;
      check("fl_stall_masked", {31'h0, stall}, 32'h0);
      tick();
      clear = 1'b0;
      check("fl_dec_ir", dec_ir, NOPI);
      check("fl_dec_pc", dec_pc, 32'h38);
      check("fl_exe_ir", exe_ir, NOPI);
      check("fl_exe_pc", exe_pc, 32'h34);
      check("fl_dv_ev", {30'h0, dec_v, exe_v}, 32'h0);
      check("fl_mem_ir", mem_ir, LW5);
      check("fl_mem_pc", mem_pc, 32'h30);
      check("fl_flush_cnt", {30'h0, flush_cnt}, 32'h1);
      check("fl_stall_cnt", {30'h0, stall_cnt}, 32'h1);

      // CLEAR and INT_TAKEN together count as a single flush
      fetch(ADDI1, 32'h40); tick();
      fetch(ADDI2, 32'h44);
      clear = 1'b1;
      int_taken = 1'b1;
      tick();
      clear = 1'b0;
      int_taken = 1'b0;
      check("both_flush_cnt", {30'h0, flush_cnt}, 32'h2);
      check("both_dec_pc", dec_pc, 32'h44);
      check("both_exe_pc", exe_pc, 32'h40);
      check("both_valids", {29'h0, dec_v, exe_v, mem_v}, 32'h0);

      // Reset in the middle of a stall
      fetch(LW5, 32'h50);   tick();
      fetch(ADD65, 32'h54); tick();
      check("rs_stall_hi", {31'h0, stall}, 32'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      if_valid = 1'b0;
      check("rs_stall_lo", {31'h0, stall}, 32'h0);
      check("rs_dec_ir", dec_ir, NOPI);
      check("rs_exe_ir", exe_ir, NOPI);
      check("rs_mem_pc", mem_pc, 32'h0);
      check("rs_valids", {28'h0, dec_v, exe_v, mem_v, wb_v}, 32'h0);
      check("rs_cnts", {28'h0, stall_cnt, flush_cnt}, 32'h0);

      // Stall counter saturates at 3 with CNT_W=2
      for (int k = 1; k <= 5; k++) begin
         fetch(LW5, 32'h100);  tick();
         fetch(ADD65, 32'h104); tick();
         check("sat_stall_hi", {31'h0, stall}, 32'h1);
         tick();
         check("sat_stall_cnt", {30'h0, stall_cnt}, (k < 3) ? k : 3);
         fetch(ADDI1, 32'h108); tick();
      end

      // Flush counter saturates too
      clear = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         check("sat_flush_cnt", {30'h0, flush_cnt}, (k < 3) ? k : 3);
      end
      clear = 1'b0;
      tick();
      check("sat_flush_hold", {30'h0, flush_cnt}, 32'h3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
